// File: rtl/dift_pkg.sv
// Shared DIFT definitions: tag width, tag type and default tag constants
// used by the tag-aware TCDM bridge and its helpers.
package dift_pkg;

    localparam int unsigned TAG_W = 4;

    typedef logic [TAG_W-1:0] tag_t;

    localparam tag_t DEFAULT_TAG_RESET = 4'b0000;
    localparam tag_t DEFAULT_TAG_OOR   = 4'b1111;

endpackage

// File: rtl/dift_tag_fifo.sv
// In-order tag queue: holds the tag sampled at grant time until the matching
// downstream response arrives. Counter plus wrapping read/write pointers.
module dift_tag_fifo
    import dift_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  tag_t data_i,
    input  logic pop_i,
    output tag_t head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    tag_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i & ~full_o;
    // A pop with nothing queued is a protocol error; it must not underflow.
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    pop_on_empty_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && empty_o));

endmodule

// File: rtl/tcdm_bus_convert_36_to_32.sv
// Tag-aware 36-bit TCDM slave to plain 32-bit TCDM master bridge. Data goes
// to memory; per-byte tags live in a local shadow array indexed by word.
module tcdm_bus_convert_36_to_32
    import dift_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h1C00_0000,
    parameter int unsigned TAG_DEPTH       = 1024,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter tag_t        TAG_RESET_VALUE = DEFAULT_TAG_RESET,
    parameter tag_t        TAG_OOR_VALUE   = DEFAULT_TAG_OOR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        slave_req_i,
    input  logic [31:0] slave_add_i,
    input  logic        slave_wen_i,
    input  logic [3:0]  slave_be_i,
    input  logic [35:0] slave_wdata_i,
    output logic        slave_gnt_o,
    output logic        slave_r_valid_o,
    output logic        slave_r_opc_o,
    output logic [35:0] slave_r_rdata_o,
    output logic        master_req_o,
    output logic [31:0] master_add_o,
    output logic        master_wen_o,
    output logic [3:0]  master_be_o,
    output logic [31:0] master_wdata_o,
    input  logic        master_gnt_i,
    input  logic        master_r_valid_i,
    input  logic        master_r_opc_i,
    input  logic [31:0] master_r_rdata_i
);

    localparam int unsigned IDX_W        = $clog2(TAG_DEPTH);
    localparam logic [31:0] REGION_BYTES = 32'(4 * TAG_DEPTH);

    tag_t             tag_q [TAG_DEPTH];
    tag_t             tag_wr_d;
    tag_t             sample_tag;
    tag_t             fifo_head;
    logic             fifo_full, fifo_empty;
    logic             grant;
    logic             tag_wr_en;
    logic [31:0]      offset;
    logic             in_region;
    logic [IDX_W-1:0] idx;

    // Unsigned subtraction makes addresses below the base wrap high and fail
    // the range check, so one compare covers both ends of the region.
    assign offset    = slave_add_i - BASE_ADDR;
    assign in_region = (offset < REGION_BYTES);
    assign idx       = offset[IDX_W+1:2];

    assign master_req_o   = slave_req_i & ~fifo_full;
    assign slave_gnt_o    = master_gnt_i & ~fifo_full;
    assign master_add_o   = slave_add_i;
    assign master_wen_o   = slave_wen_i;
    assign master_be_o    = slave_be_i;
    assign master_wdata_o = slave_wdata_i[31:0];

    assign grant     = slave_req_i & slave_gnt_o;
    assign tag_wr_en = grant & ~slave_wen_i & in_region;

    always_comb begin
        tag_wr_d = tag_q[idx];
        for (int b = 0; b < TAG_W; b++) begin
            if (slave_be_i[b]) begin
                tag_wr_d[b] = slave_wdata_i[32+b];
            end
        end
    end

    always_comb begin
        sample_tag = '0;
        if (slave_wen_i) begin
            sample_tag = in_region ? tag_q[idx] : TAG_OOR_VALUE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(TAG_DEPTH); i++) begin
                tag_q[i] <= TAG_RESET_VALUE;
            end
        end else if (tag_wr_en) begin
            tag_q[idx] <= tag_wr_d;
        end
    end

    dift_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) i_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .data_i  (sample_tag),
        .pop_i   (master_r_valid_i),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign slave_r_valid_o = master_r_valid_i;
    assign slave_r_opc_o   = master_r_opc_i;
    assign slave_r_rdata_o = {(fifo_empty ? tag_t'('0) : fifo_head), master_r_rdata_i};

endmodule

// File: tb/tb_tcdm_bus_convert_36_to_32.sv
// Bench for the 36-to-32 TCDM tag bridge: directed vector table against a
// small delayed-response memory model, plus back-pressure and reset sequences.
module tb_tcdm_bus_convert_36_to_32;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        slave_req_i = 1'b0;
    logic [31:0] slave_add_i = '0;
    logic        slave_wen_i = 1'b1;
    logic [3:0]  slave_be_i = '0;
    logic [35:0] slave_wdata_i = '0;
    logic        slave_gnt_o, slave_r_valid_o, slave_r_opc_o;
    logic [35:0] slave_r_rdata_o;
    logic        master_req_o, master_wen_o;
    logic [31:0] master_add_o, master_wdata_o;
    logic [3:0]  master_be_o;
    logic        master_gnt_i = 1'b1;
    logic        m_r_valid, m_r_opc;
    logic [31:0] m_rdata;

    always #5 clk_i = ~clk_i;

    tcdm_bus_convert_36_to_32 dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .slave_req_i      (slave_req_i),
        .slave_add_i      (slave_add_i),
        .slave_wen_i      (slave_wen_i),
        .slave_be_i       (slave_be_i),
        .slave_wdata_i    (slave_wdata_i),
        .slave_gnt_o      (slave_gnt_o),
        .slave_r_valid_o  (slave_r_valid_o),
        .slave_r_opc_o    (slave_r_opc_o),
        .slave_r_rdata_o  (slave_r_rdata_o),
        .master_req_o     (master_req_o),
        .master_add_o     (master_add_o),
        .master_wen_o     (master_wen_o),
        .master_be_o      (master_be_o),
        .master_wdata_o   (master_wdata_o),
        .master_gnt_i     (master_gnt_i),
        .master_r_valid_i (m_r_valid),
        .master_r_opc_i   (m_r_opc),
        .master_r_rdata_i (m_rdata)
    );

    // Downstream memory: word 1025 is a sink for unmapped addresses.
    logic [31:0] mem [0:1025];
    int          mem_delay = 2;
    int          cyc;
    int          q_due [0:15];
    logic [31:0] q_dat [0:15];
    logic [3:0]  q_wr, q_rd;
    int          m_idx;

    function automatic int midx(input logic [31:0] a);
        if (a[31:12] == 20'h1C000) return int'(a[11:2]);
        if (a[31:2] == 30'h0700_4000) return 1024;
        return 1025;
    endfunction

    function automatic logic [31:0] bemerge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    assign m_idx = midx(master_add_o);

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc       <= 0;
            q_wr      <= '0;
            q_rd      <= '0;
            m_r_valid <= 1'b0;
            m_r_opc   <= 1'b0;
            m_rdata   <= '0;
            for (int i = 0; i < 1026; i++) mem[i] <= 32'h0;
            mem[0]    <= 32'hDEADBEEF;
            mem[1024] <= 32'hCAFEF00D;
        end else begin
            cyc <= cyc + 1;
            if (master_req_o && master_gnt_i) begin
                q_due[q_wr] <= cyc + mem_delay;
                q_dat[q_wr] <= (master_wen_o && m_idx != 1025) ? mem[m_idx] : 32'h0;
                q_wr        <= q_wr + 4'd1;
                if (!master_wen_o && m_idx != 1025)
                    mem[m_idx] <= bemerge(mem[m_idx], master_wdata_o, master_be_o);
            end
            if (q_rd != q_wr && q_due[q_rd] <= cyc + 1) begin
                m_r_valid <= 1'b1;
                m_rdata   <= q_dat[q_rd];
                q_rd      <= q_rd + 4'd1;
            end else begin
                m_r_valid <= 1'b0;
                m_rdata   <= '0;
            end
        end
    end

    logic [35:0] rsp_buf [0:63];
    logic [5:0]  rsp_n = '0;
    logic [5:0]  rsp_rd = '0;

    always @(negedge clk_i) begin
        if (slave_r_valid_o) begin
            rsp_buf[rsp_n] <= slave_r_rdata_o;
            rsp_n          <= rsp_n + 6'd1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic wen, input logic [31:0] add, input logic [3:0] be,
                         input logic [35:0] wdata);
        bit granted;
        granted = 1'b0;
        @(negedge clk_i);
        slave_req_i   = 1'b1;
        slave_wen_i   = wen;
        slave_add_i   = add;
        slave_be_i    = be;
        slave_wdata_i = wdata;
        #1;
        for (int t = 0; t < 30 && !granted; t++) begin
            if (slave_gnt_o) granted = 1'b1;
            else begin
                @(negedge clk_i);
                #1;
            end
        end
        if (granted) begin
            chk("passthrough", {master_req_o, master_wen_o, master_be_o, master_add_o[29:0]},
                {1'b1, wen, be, add[29:0]});
            chk("wdata_pass", 36'(master_wdata_o), 36'(wdata[31:0]));
            @(posedge clk_i);
            #1;
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL grant_timeout: add %h never granted", add);
        end
        slave_req_i = 1'b0;
    endtask

    task automatic wait_rsp(output logic [35:0] data);
        data = 36'hx;
        for (int t = 0; t < 30; t++) begin
            if (rsp_rd != rsp_n) begin
                data   = rsp_buf[rsp_rd];
                rsp_rd = rsp_rd + 6'd1;
                return;
            end
            @(negedge clk_i);
            #1;
        end
    endtask

    typedef struct packed {
        logic        wen;
        logic [31:0] add;
        logic [3:0]  be;
        logic [35:0] wdata;
        logic [35:0] exp;
    } vec_t;

    localparam int NV = 16;
    vec_t        vecs [NV];
    logic [31:0] a_add [5];
    logic [35:0] a_exp [5];

    initial begin
        logic [35:0] d;
        int          k, grants;
        bit          seen, chk_next;

        vecs[0]  = '{1'b1, 32'h1C00_0000, 4'hF, 36'h0,           36'h0_DEADBEEF};
        vecs[1]  = '{1'b0, 32'h1C00_0010, 4'hF, 36'hA_12345678,  36'h0_00000000};
        vecs[2]  = '{1'b1, 32'h1C00_0010, 4'hF, 36'h0,           36'hA_12345678};
        vecs[3]  = '{1'b0, 32'h1C00_0010, 4'h2, 36'h0_00009900,  36'h0_00000000};
        vecs[4]  = '{1'b1, 32'h1C00_0010, 4'hF, 36'h0,           36'h8_12349978};
        vecs[5]  = '{1'b1, 32'h1C01_0000, 4'hF, 36'h0,           36'hF_CAFEF00D};
        vecs[6]  = '{1'b0, 32'h1C01_0000, 4'hF, 36'h5_00000001,  36'h0_00000000};
        vecs[7]  = '{1'b1, 32'h1C00_0010, 4'hF, 36'h0,           36'h8_12349978};
        vecs[8]  = '{1'b1, 32'h1C01_0000, 4'hF, 36'h0,           36'hF_00000001};
        vecs[9]  = '{1'b1, 32'h1C00_0013, 4'hF, 36'h0,           36'h8_12349978};
        vecs[10] = '{1'b0, 32'h1C00_0FFC, 4'h9, 36'hF_11223344,  36'h0_00000000};
        vecs[11] = '{1'b1, 32'h1C00_0FFC, 4'hF, 36'h0,           36'h9_11000044};
        vecs[12] = '{1'b1, 32'h1C00_1000, 4'hF, 36'h0,           36'hF_00000000};
        vecs[13] = '{1'b1, 32'h1BFF_FFFC, 4'hF, 36'h0,           36'hF_00000000};
        vecs[14] = '{1'b0, 32'h1C00_1000, 4'hF, 36'h3_00000077,  36'h0_00000000};
        vecs[15] = '{1'b1, 32'h1C00_0000, 4'hF, 36'h0,           36'h0_DEADBEEF};

        // Reset state: grant follows downstream, request passes, no tag out.
        slave_req_i = 1'b1;
        #2;
        chk("rst_gnt", 36'(slave_gnt_o), 36'h1);
        chk("rst_req", 36'(master_req_o), 36'h1);
        chk("rst_tag", 36'(slave_r_rdata_o[35:32]), 36'h0);
        chk("rst_rvalid", 36'(slave_r_valid_o), 36'h0);
        slave_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].wen, vecs[i].add, vecs[i].be, vecs[i].wdata);
            wait_rsp(d);
            chk($sformatf("vec%0d", i), d, vecs[i].exp);
        end
        // Extra per-lane check: lanes 0 and 2 set, others cleared.
        issue(1'b0, 32'h1C00_0020, 4'h5, 36'hF_AABBCCDD);
        wait_rsp(d);
        issue(1'b1, 32'h1C00_0020, 4'hF, 36'h0);
        wait_rsp(d);
        chk("lane_mask", d, 36'h5_00BB00DD);

        // Five back-to-back reads against a slow memory fill the queue.
        a_add[0] = 32'h1C00_0010; a_exp[0] = 36'h8_12349978;
        a_add[1] = 32'h1C00_0FFC; a_exp[1] = 36'h9_11000044;
        a_add[2] = 32'h1C01_0000; a_exp[2] = 36'hF_00000001;
        a_add[3] = 32'h1C00_0020; a_exp[3] = 36'h5_00BB00DD;
        a_add[4] = 32'h1C00_0000; a_exp[4] = 36'h0_DEADBEEF;
        repeat (4) @(negedge clk_i);
        mem_delay = 6;
        rsp_rd    = rsp_n;
        k = 0; grants = 0; seen = 1'b0; chk_next = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_i);
            if (k < 5) begin
                slave_req_i   = 1'b1;
                slave_wen_i   = 1'b1;
                slave_add_i   = a_add[k];
                slave_be_i    = 4'hF;
                slave_wdata_i = '0;
            end else begin
                slave_req_i = 1'b0;
            end
            #1;
            if (chk_next) begin
                chk("gnt_after_pop", 36'(slave_gnt_o), 36'h1);
                chk_next = 1'b0;
            end
            if (slave_r_valid_o && !seen) begin
                seen = 1'b1;
                chk("grants_at_full", 36'(grants), 36'd4);
                chk("gnt_held_full", 36'(slave_gnt_o), 36'h0);
                chk_next = 1'b1;
            end
            if (slave_req_i && slave_gnt_o) begin
                grants++;
                k++;
            end
            if (k == 5 && (rsp_n - rsp_rd) == 6'd5) break;
        end
        slave_req_i = 1'b0;
        chk("saw_rvalid", 36'(seen), 36'h1);
        for (int j = 0; j < 5; j++) begin
            wait_rsp(d);
            chk($sformatf("ooo_rsp%0d", j), d, a_exp[j]);
        end

        // Reset with two reads in flight.
        repeat (10) @(negedge clk_i);
        issue(1'b1, 32'h1C00_0010, 4'hF, 36'h0);
        issue(1'b1, 32'h1C00_0FFC, 4'hF, 36'h0);
        @(negedge clk_i);
        #1;
        chk("head_before_rst", 36'(slave_r_rdata_o[35:32]), 36'h8);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_tag", 36'(slave_r_rdata_o[35:32]), 36'h0);
        chk("rst_mid_gnt", 36'(slave_gnt_o), 36'h1);
        master_gnt_i = 1'b0;
        #1;
        chk("rst_gnt_follow", 36'(slave_gnt_o), 36'h0);
        master_gnt_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        mem_delay = 2;
        rsp_rd    = rsp_n;
        issue(1'b1, 32'h1C00_0010, 4'hF, 36'h0);
        wait_rsp(d);
        chk("post_rst_0010", d, 36'h0_00000000);
        issue(1'b1, 32'h1C00_0FFC, 4'hF, 36'h0);
        wait_rsp(d);
        chk("post_rst_0ffc", d, 36'h0_00000000);

        repeat (4) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/tcdm_bus_convert_36_to_32.md
Name: tcdm_bus_convert_36_to_32

Overview:
- Slave-side bridge for the DIFT extension: accepts XBAR_TCDM_BUS_36 traffic from a tag-aware initiator and forwards it to a plain 32-bit XBAR_TCDM_BUS memory.
- Data bits [31:0] go to memory. Tag bits [35:32] (one per byte lane) are kept in a local shadow tag array indexed by word address.
- Read responses are re-assembled as {tag, data}. An in-order outstanding-response FIFO aligns the tags sampled at grant time with the memory's r_valid data.

Parameters:
- BASE_ADDR, 32'h1C00_0000, byte base address of the tagged region.
- TAG_DEPTH, 1024, number of 32-bit words covered by the tag array (power of two).
- MAX_OUTSTANDING, 4, outstanding-response FIFO depth (power of two, >=2).
- TAG_RESET_VALUE, 4'b0000, tag value of every entry after reset.
- TAG_OOR_VALUE, 4'b1111, tag returned for reads outside the tagged region.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- slave_36  XBAR_TCDM_BUS_36.Slave  -  tag-aware request/response port (req, add[31:0], wen, be[3:0], wdata[35:0], gnt, r_valid, r_opc, r_rdata[35:0])
- master_32  XBAR_TCDM_BUS.Master  -  downstream 32-bit memory port

Behaviour:
- Protocol:
  - wen=1 is a read, wen=0 is a write.
  - A transfer occurs in a cycle with req&gnt.
  - Downstream returns exactly one r_valid per granted request (reads and writes), in order, at least 1 cycle after grant.
- Request path:
  - master_32.req = slave_36.req & !fifo_full.
  - slave_36.gnt = master_32.gnt & !fifo_full.
  - add, wen and be pass through unchanged; master_32.wdata = slave_36.wdata[31:0].
- Region decode:
  - in_region = (add - BASE_ADDR) < 4*TAG_DEPTH.
  - idx = (add - BASE_ADDR)[log2(TAG_DEPTH)+1:2]. Low two address bits are ignored.
- Tag write: on a granted write with in_region, for each i in 0..3 with be[i]=1, tag[idx][i] <= wdata[32+i] at that clock edge. Out-of-region writes leave the tag array untouched.
- Tag sample: on every grant, push one entry into the FIFO:
  - read, in region: tag[idx] as stored before this edge.
  - read, out of region: TAG_OOR_VALUE.
  - write: 4'b0000.
- Response path (combinational from master_32 and FIFO head):
  - slave_36.r_valid = master_32.r_valid.
  - slave_36.r_opc = master_32.r_opc.
  - slave_36.r_rdata = {fifo_head, master_32.r_rdata}.
  - FIFO pops on master_32.r_valid.
- Latency: zero added cycles on both request and response paths.
- Ordering: a read granted in a later cycle than a write to the same word observes the new tag. Same-cycle read/write is impossible (single port).
- FIFO:
  - Counter plus read/write pointers, pointers wrap modulo MAX_OUTSTANDING.
  - Push and pop in the same cycle leave the count unchanged.
  - When full, gnt is held low. A same-cycle pop does not bypass full; the grant happens next cycle.
- Error case: r_valid with the FIFO empty returns tag 4'b0000, leaves the count at 0 and fires a simulation assertion.
- Reset (asynchronous, rst_ni=0):
  - FIFO empty, pointers and count 0.
  - All tag entries set to TAG_RESET_VALUE.
  - Outputs driven combinationally: gnt follows master_32.gnt, r_rdata[35:32]=0.
- Reset mid-operation discards in-flight tag entries. The downstream memory must be reset together with this block.

Decomposition:
- Shared package dift_pkg: TAG_W=4, tag_t typedef, TAG_RESET_VALUE/TAG_OOR_VALUE defaults.
- Sub-module dift_tag_fifo (parameterised depth, width TAG_W, push/pop/full/empty) instantiated for the outstanding-response queue.
- Tag array and region decode stay in the top module.

Test Plan:
- Reset, then read 0x1C00_0000 (memory holds 0xDEADBEEF) -> r_rdata = 36'h0_DEADBEEF, one r_valid.
- Write 0x1C00_0010, wdata=36'hA_12345678, be=4'b1111, then read the same address -> r_rdata[35:32]=4'hA, r_rdata[31:0]=32'h12345678.
- Write 0x1C00_0010, be=4'b0010, wdata[35:32]=4'h0 over the stored tag 4'hA -> subsequent read returns tag 4'h8.
- Read 0x1C01_0000 (out of region, TAG_DEPTH=1024) -> tag 4'hF; a write there leaves in-region tags unchanged.
- Downstream with a 6-cycle response delay and 5 back-to-back reads, MAX_OUTSTANDING=4 -> 4 grants, gnt low on the 5th until the first r_valid, then granted next cycle; all tags returned in order.
- Assert rst_ni low with 2 reads outstanding -> FIFO empty and tags back to 4'h0 immediately; a fresh read after release returns tag 4'h0.
